// File: rtl/commutativity_scan_engine.sv
// Sequenced scan over the stabilizer shift-register array: measure (pivot replace / row multiply),
// Toffoli phase toggle, and external row load, one row per cycle.
module commutativity_scan_engine #(
    parameter int num_qubit  = 3,
    parameter int max_vector = 2**num_qubit,
    parameter int COL_W      = (num_qubit > 1) ? $clog2(num_qubit) : 1,
    parameter int CNT_W      = $clog2(num_qubit + 1)
) (
    input  logic                   clk,
    input  logic                   rst_anticommute,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic                   obs_sel,
    input  logic [COL_W-1:0]       col_sel,
    input  logic [2*num_qubit-1:0] literals_shift_out,
    input  logic [max_vector-1:0]  phase_shift_out,
    input  logic [2*num_qubit-1:0] literals_in,
    input  logic [max_vector-1:0]  phase_in,
    input  logic [max_vector-1:0]  flag_nonstabilizer_update,
    output logic [2*num_qubit-1:0] literals_shift_in,
    output logic [max_vector-1:0]  phase_shift_in,
    output logic                   shift_en,
    output logic                   busy,
    output logic                   done,
    output logic                   flag_anticommute,
    output logic [CNT_W-1:0]       anticommute_count,
    output logic [COL_W-1:0]       pivot_index,
    output logic                   deterministic,
    output logic [2*num_qubit-1:0] literals_anticommute,
    output logic [max_vector-1:0]  phase_anticommute
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

    state_t                 r_state, w_state_next;
    logic [1:0]             r_mode;
    logic                   r_obs;
    logic [COL_W-1:0]       r_col;
    logic [COL_W-1:0]       r_row_cnt;
    logic [CNT_W-1:0]       r_count;
    logic                   r_flag;
    logic [COL_W-1:0]       r_pivot_index;
    logic [2*num_qubit-1:0] r_piv_lit;
    logic [max_vector-1:0]  r_piv_phase;

    logic                   w_start_ok;
    logic [1:0]             w_head_lit;
    logic                   w_anti;
    logic [2*num_qubit-1:0] w_basis;
    logic [2*num_qubit-1:0] w_prod_lit;
    logic [1:0]             w_sum;
    logic [max_vector-1:0]  w_prod_phase;

    // i-power (mod 4) contributed by one column when the pivot literal p left-multiplies target t.
    function automatic logic [1:0] g_term(input logic [1:0] p, input logic [1:0] t);
        logic [1:0] g;
        g = 2'd0;
        case (p)
            2'd3: g = (t == 2'd1) ? 2'd1 : ((t == 2'd2) ? 2'd3 : 2'd0);
            2'd2: g = (t == 2'd1) ? 2'd3 : ((t == 2'd3) ? 2'd1 : 2'd0);
            2'd1: g = (t == 2'd2) ? 2'd1 : ((t == 2'd3) ? 2'd3 : 2'd0);
            default: g = 2'd0;
        endcase
        return g;
    endfunction

    assign w_start_ok = start && (mode != 2'd3);
    assign w_head_lit = literals_shift_out[2*r_col +: 2];
    assign w_anti     = (r_state == S_SCAN) && (r_mode == 2'd0) &&
                        (r_obs ? w_head_lit[0] : w_head_lit[1]);
    assign w_prod_lit = literals_shift_out ^ r_piv_lit;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_basis = '0;
        w_basis[2*r_col +: 2] = r_obs ? 2'd2 : 2'd1;
        w_sum = 2'd0;
        for (int c = 0; c < num_qubit; c++)
            w_sum = w_sum + g_term(r_piv_lit[2*c +: 2], literals_shift_out[2*c +: 2]);
        w_prod_phase = phase_shift_out ^ r_piv_phase ^ {max_vector{w_sum[1]}};
    end

    always_comb begin
        w_state_next      = r_state;
        shift_en          = 1'b0;
        busy              = 1'b0;
        done              = 1'b0;
        deterministic     = 1'b0;
        literals_shift_in = literals_shift_out;
        phase_shift_in    = phase_shift_out;
        case (r_state)
            S_IDLE: if (w_start_ok) w_state_next = S_SCAN;
            S_SCAN: begin
                busy     = 1'b1;
                shift_en = 1'b1;
                if (r_row_cnt == COL_W'(num_qubit - 1)) w_state_next = S_DONE;
                case (r_mode)
                    2'd0: if (w_anti) begin
                        if (!r_flag) begin
                            literals_shift_in = w_basis;
                        end else begin
                            literals_shift_in = w_prod_lit;
                            phase_shift_in    = w_prod_phase;
                        end
                    end
                    2'd1: phase_shift_in = phase_shift_out ^ flag_nonstabilizer_update;
                    2'd2: begin
                        literals_shift_in = literals_in;
                        phase_shift_in    = phase_in;
                    end
                    default: ;
                endcase
            end
            S_DONE: begin
                busy          = 1'b1;
                done          = 1'b1;
                deterministic = (r_mode == 2'd0) && (r_count == '0);
                w_state_next  = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst_anticommute) begin
        if (rst_anticommute) begin
            r_state       <= S_IDLE;
            r_mode        <= 2'd0;
            r_obs         <= 1'b0;
            r_col         <= '0;
            r_row_cnt     <= '0;
            r_count       <= '0;
            r_flag        <= 1'b0;
            r_pivot_index <= '0;
            r_piv_lit     <= '0;
            r_piv_phase   <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == S_IDLE && w_start_ok) begin
                r_mode        <= mode;
                r_obs         <= obs_sel;
                r_col         <= (int'(col_sel) < num_qubit) ? col_sel : '0;
                r_row_cnt     <= '0;
                r_count       <= '0;
                r_flag        <= 1'b0;
                r_pivot_index <= '0;
                r_piv_lit     <= '0;
                r_piv_phase   <= '0;
            end else if (r_state == S_SCAN) begin
                r_row_cnt <= r_row_cnt + COL_W'(1);
                if (w_anti) begin
                    if (r_count != CNT_W'(num_qubit)) r_count <= r_count + CNT_W'(1);
                    // The original anticommuting row is kept as the multiplier for later rows.
                    if (!r_flag) begin
                        r_flag        <= 1'b1;
                        r_pivot_index <= r_row_cnt;
                        r_piv_lit     <= literals_shift_out;
                        r_piv_phase   <= phase_shift_out;
                    end
                end
            end
        end
    end

    assign flag_anticommute     = r_flag;
    assign anticommute_count    = r_count;
    assign pivot_index          = r_pivot_index;
    assign literals_anticommute = r_piv_lit;
    assign phase_anticommute    = r_piv_phase;

endmodule

// File: tb/tb_commutativity_scan_engine.sv
// Directed bench for commutativity_scan_engine: models the rotating stabilizer array and
// checks each pass against hand-computed rows, phases and status.
module tb_commutativity_scan_engine;

    localparam int NQ = 3;
    localparam int MV = 8;
    localparam int COL_W = 2;
    localparam int CNT_W = 2;
    localparam logic [1:0] LI = 2'd0, LZ = 2'd1, LX = 2'd2, LY = 2'd3;

    logic clk = 1'b0;
    logic rst_anticommute, start, obs_sel;
    logic [1:0] mode;
    logic [COL_W-1:0] col_sel;
    logic [2*NQ-1:0] literals_shift_out, literals_in, literals_shift_in, literals_anticommute;
    logic [MV-1:0] phase_shift_out, phase_in, flag_nonstabilizer_update, phase_shift_in, phase_anticommute;
    logic shift_en, busy, done, flag_anticommute, deterministic;
    logic [CNT_W-1:0] anticommute_count;
    logic [COL_W-1:0] pivot_index;

    int n_checks = 0;
    int n_errors = 0;

    logic [2*NQ-1:0] arr_lit [NQ];
    logic [MV-1:0]   arr_ph  [NQ];
    logic [2*NQ-1:0] stage_lit [NQ];
    logic [MV-1:0]   stage_ph  [NQ];
    logic            load_en;

    always #5 clk = ~clk;

    commutativity_scan_engine #(.num_qubit(NQ), .max_vector(MV)) dut (
        .clk(clk), .rst_anticommute(rst_anticommute), .start(start), .mode(mode),
        .obs_sel(obs_sel), .col_sel(col_sel),
        .literals_shift_out(literals_shift_out), .phase_shift_out(phase_shift_out),
        .literals_in(literals_in), .phase_in(phase_in),
        .flag_nonstabilizer_update(flag_nonstabilizer_update),
        .literals_shift_in(literals_shift_in), .phase_shift_in(phase_shift_in),
        .shift_en(shift_en), .busy(busy), .done(done), .flag_anticommute(flag_anticommute),
        .anticommute_count(anticommute_count), .pivot_index(pivot_index),
        .deterministic(deterministic), .literals_anticommute(literals_anticommute),
        .phase_anticommute(phase_anticommute)
    );

    // External array: head row feeds the engine, written-back row enters at the tail.
    assign literals_shift_out = arr_lit[0];
    assign phase_shift_out    = arr_ph[0];

    always @(posedge clk) begin
        if (load_en) begin
            for (int i = 0; i < NQ; i++) begin
                arr_lit[i] <= stage_lit[i];
                arr_ph[i]  <= stage_ph[i];
            end
        end else if (shift_en) begin
            for (int i = 0; i < NQ-1; i++) begin
                arr_lit[i] <= arr_lit[i+1];
                arr_ph[i]  <= arr_ph[i+1];
            end
            arr_lit[NQ-1] <= literals_shift_in;
            arr_ph[NQ-1]  <= phase_shift_in;
        end
    end

    function automatic logic [2*NQ-1:0] row3(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c);
        return {c, b, a};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic load_array(input logic [2*NQ-1:0] l0, input logic [2*NQ-1:0] l1, input logic [2*NQ-1:0] l2,
                              input logic [MV-1:0] p0, input logic [MV-1:0] p1, input logic [MV-1:0] p2);
        @(negedge clk);
        stage_lit[0] = l0; stage_lit[1] = l1; stage_lit[2] = l2;
        stage_ph[0]  = p0; stage_ph[1]  = p1; stage_ph[2]  = p2;
        load_en = 1'b1;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic check_array(input string tag,
                               input logic [2*NQ-1:0] l0, input logic [2*NQ-1:0] l1, input logic [2*NQ-1:0] l2,
                               input logic [MV-1:0] p0, input logic [MV-1:0] p1, input logic [MV-1:0] p2);
        check({tag, "_r0_lit"}, 32'(arr_lit[0]), 32'(l0));
        check({tag, "_r1_lit"}, 32'(arr_lit[1]), 32'(l1));
        check({tag, "_r2_lit"}, 32'(arr_lit[2]), 32'(l2));
        check({tag, "_r0_ph"},  32'(arr_ph[0]),  32'(p0));
        check({tag, "_r1_ph"},  32'(arr_ph[1]),  32'(p1));
        check({tag, "_r2_ph"},  32'(arr_ph[2]),  32'(p2));
    endtask

    // Starts one pass and returns the cycle at which done was seen, shift cycles, and deterministic.
    task automatic run_pass(input logic [1:0] m, input logic o, input logic [COL_W-1:0] c,
                            output int lat, output int sc, output logic det);
        @(negedge clk);
        mode = m; obs_sel = o; col_sel = c; start = 1'b1;
        sc = 0;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        if (shift_en) sc++;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            if (shift_en) sc++;
        end
        det = deterministic;
        @(negedge clk);
    endtask

    task automatic check_status(input string tag, input int lat, input int sc, input logic det,
                                input logic e_det, input int e_cnt, input logic e_flag, input int e_piv);
        check({tag, "_latency"},  32'(lat), 32'(NQ + 1));
        check({tag, "_shifts"},   32'(sc),  32'(NQ));
        check({tag, "_determ"},   32'(det), 32'(e_det));
        check({tag, "_count"},    32'(anticommute_count), 32'(e_cnt));
        check({tag, "_flag"},     32'(flag_anticommute),  32'(e_flag));
        check({tag, "_pivot"},    32'(pivot_index),       32'(e_piv));
        check({tag, "_idle"},     32'(busy), 32'd0);
    endtask

    int lat, sc;
    logic det;

    initial begin
        rst_anticommute = 1'b1;
        start = 1'b0; mode = 2'd0; obs_sel = 1'b0; col_sel = '0;
        literals_in = '0; phase_in = '0; flag_nonstabilizer_update = '0;
        load_en = 1'b0;
        for (int i = 0; i < NQ; i++) begin
            stage_lit[i] = '0;
            stage_ph[i]  = '0;
        end

        // Reset state, with a known head row for the passthrough check.
        load_array(row3(LX, LZ, LY), row3(LI, LI, LI), row3(LI, LI, LI), 8'h5A, 8'h00, 8'h00);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_shift", 32'(shift_en), 32'd0);
        check("rst_flag",  32'(flag_anticommute), 32'd0);
        check("rst_count", 32'(anticommute_count), 32'd0);
        check("rst_pivot", 32'(pivot_index), 32'd0);
        check("rst_det",   32'(deterministic), 32'd0);
        check("rst_pass_lit", 32'(literals_shift_in), 32'(row3(LX, LZ, LY)));
        check("rst_pass_ph",  32'(phase_shift_in), 32'h5A);
        @(negedge clk);
        rst_anticommute = 1'b0;

        // Reset mid-SCAN after the pivot was captured aborts the pass.
        load_array(row3(LX, LI, LI), row3(LZ, LZ, LI), row3(LY, LZ, LI), 8'hA5, 8'h3C, 8'h0F);
        @(negedge clk);
        mode = 2'd0; obs_sel = 1'b0; col_sel = 2'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_flag_set", 32'(flag_anticommute), 32'd1);
        rst_anticommute = 1'b1;
        #1;
        check("mid_rst_busy",  32'(busy), 32'd0);
        check("mid_rst_shift", 32'(shift_en), 32'd0);
        check("mid_rst_flag",  32'(flag_anticommute), 32'd0);
        check("mid_rst_count", 32'(anticommute_count), 32'd0);
        @(negedge clk);
        rst_anticommute = 1'b0;

        // No anticommuting row: deterministic outcome, array untouched.
        load_array(row3(LZ, LI, LI), row3(LI, LZ, LI), row3(LI, LI, LZ), 8'h11, 8'h22, 8'h33);
        run_pass(2'd0, 1'b0, 2'd0, lat, sc, det);
        check_status("det", lat, sc, det, 1'b1, 0, 1'b0, 0);
        check_array("det", row3(LZ, LI, LI), row3(LI, LZ, LI), row3(LI, LI, LZ), 8'h11, 8'h22, 8'h33);

        // Z obs col 0: pivot row 0 -> Z I I; row 2 = Y Z I * X I I = Z Z I, sign 0.
        load_array(row3(LX, LI, LI), row3(LZ, LZ, LI), row3(LY, LZ, LI), 8'hA5, 8'h3C, 8'h0F);
        run_pass(2'd0, 1'b0, 2'd0, lat, sc, det);
        check_status("zobs", lat, sc, det, 1'b0, 2, 1'b1, 0);
        check("zobs_piv_lit", 32'(literals_anticommute), 32'(row3(LX, LI, LI)));
        check("zobs_piv_ph",  32'(phase_anticommute), 32'hA5);
        check_array("zobs", row3(LZ, LI, LI), row3(LZ, LZ, LI), row3(LZ, LZ, LI), 8'hA5, 8'h3C, 8'hAA);

        // X obs col 2: pivot row 1 -> I I X; row 2 = I X Y * Z I Z = Z X X, i-power 3 -> sign 1.
        load_array(row3(LI, LI, LX), row3(LZ, LI, LZ), row3(LI, LX, LY), 8'h01, 8'h0F, 8'hF0);
        run_pass(2'd0, 1'b1, 2'd2, lat, sc, det);
        check_status("xobs", lat, sc, det, 1'b0, 2, 1'b1, 1);
        check_array("xobs", row3(LI, LI, LX), row3(LI, LI, LX), row3(LZ, LX, LX), 8'h01, 8'h0F, 8'h00);

        // col_sel out of range acts as col 0; pivot on the last row still captures.
        load_array(row3(LZ, LI, LI), row3(LI, LI, LI), row3(LY, LZ, LX), 8'h12, 8'h34, 8'h56);
        run_pass(2'd0, 1'b0, 2'd3, lat, sc, det);
        check_status("lastpiv", lat, sc, det, 1'b0, 1, 1'b1, 2);
        check("lastpiv_piv_lit", 32'(literals_anticommute), 32'(row3(LY, LZ, LX)));
        check_array("lastpiv", row3(LZ, LI, LI), row3(LI, LI, LI), row3(LZ, LI, LI), 8'h12, 8'h34, 8'h56);

        // Toffoli pass: phases XOR mask, literals kept.
        load_array(row3(LZ, LX, LY), row3(LI, LI, LZ), row3(LX, LX, LX), 8'h00, 8'hFF, 8'h5A);
        flag_nonstabilizer_update = 8'b1010_0001;
        run_pass(2'd1, 1'b0, 2'd0, lat, sc, det);
        check_status("toff", lat, sc, det, 1'b0, 0, 1'b0, 0);
        check_array("toff", row3(LZ, LX, LY), row3(LI, LI, LZ), row3(LX, LX, LX), 8'hA1, 8'h5E, 8'hFB);
        flag_nonstabilizer_update = '0;

        // External load pass.
        literals_in = row3(LY, LY, LY);
        phase_in    = 8'hC3;
        run_pass(2'd2, 1'b0, 2'd0, lat, sc, det);
        check_status("ext", lat, sc, det, 1'b0, 0, 1'b0, 0);
        check_array("ext", row3(LY, LY, LY), row3(LY, LY, LY), row3(LY, LY, LY), 8'hC3, 8'hC3, 8'hC3);

        // start with mode 3 is ignored.
        @(negedge clk);
        mode = 2'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("hold_busy",  32'(busy), 32'd0);
        check("hold_shift", 32'(shift_en), 32'd0);
        @(negedge clk);
        check("hold_busy2", 32'(busy), 32'd0);

        // start held during SCAN (with a different mode) is ignored.
        load_array(row3(LZ, LI, LI), row3(LI, LZ, LI), row3(LI, LI, LZ), 8'h11, 8'h22, 8'h33);
        flag_nonstabilizer_update = 8'hFF;
        @(negedge clk);
        mode = 2'd0; obs_sel = 1'b0; col_sel = 2'd0; start = 1'b1;
        lat = 0;
        sc = 0;
        while (!done && lat < 20) begin
            @(negedge clk);
            lat++;
            mode = 2'd1;
            if (shift_en) sc++;
            if (lat >= 3) start = 1'b0;
        end
        det = deterministic;
        start = 1'b0;
        mode = 2'd0;
        @(negedge clk);
        check_status("busystart", lat, sc, det, 1'b1, 0, 1'b0, 0);
        check_array("busystart", row3(LZ, LI, LI), row3(LI, LZ, LI), row3(LI, LI, LZ), 8'h11, 8'h22, 8'h33);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
